// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard detection and forwarding unit beside the ID stage. Tracks the destination registers of
//   the DEPTH instructions in flight after ID (entry 0 = EX, 1 = MEM, ...) and produces the ID
//   stall, per-operand forwarding select/data, and saturating stall/flush counters.
// Ports
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   id_*                          decoded fields of the instruction currently in ID
//   flush                         taken branch/jump: squash ID and entry 0
//   stage_result                  slice i = result currently produced by entry i
//   stall                         hold PC and IF/ID, insert bubble into EX
//   fwd_rs_*/fwd_rt_*             forwarding hit, entry index (DEPTH if none), forwarded data
//   in_flight                     number of valid entries
//   stall_count, flush_count      saturating performance counters
module hazard_scoreboard #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned DEPTH           = 3,
    parameter int unsigned LOAD_USE_STAGES = 1,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic                          id_uses_rs,
    input  logic                          id_uses_rt,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rt_addr,
    input  logic                          id_writes_reg,
    input  logic [REG_ADDR_WIDTH-1:0]     id_dest_addr,
    input  logic                          id_is_load,
    input  logic                          flush,
    input  logic [DEPTH*DATA_WIDTH-1:0]   stage_result,
    output logic                          stall,
    output logic                          fwd_rs_hit,
    output logic                          fwd_rt_hit,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_rs_sel,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_rt_sel,
    output logic [DATA_WIDTH-1:0]         fwd_rs_data,
    output logic [DATA_WIDTH-1:0]         fwd_rt_data,
    output logic [$clog2(DEPTH+1)-1:0]    in_flight,
    output logic [COUNT_WIDTH-1:0]        stall_count,
    output logic [COUNT_WIDTH-1:0]        flush_count
);

    localparam int unsigned SelWidth = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]          valid_q, writes_q, load_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q [DEPTH];
    logic [COUNT_WIDTH-1:0]    stall_count_q, flush_count_q;

    logic [DEPTH-1:0]          live;
    logic [1:0]                op_used, op_found, op_hazard, op_hit;
    logic [REG_ADDR_WIDTH-1:0] op_addr [2];
    logic [SelWidth-1:0]       op_idx  [2];
    logic [DATA_WIDTH-1:0]     op_data [2];
    logic [SelWidth-1:0]       valid_cnt;

    assign op_used    = {id_uses_rt, id_uses_rs};
    assign op_addr[0] = id_rs_addr;
    assign op_addr[1] = id_rt_addr;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            live[i] = valid_q[i] & writes_q[i] & (dest_q[i] != '0);
        end
    end

    // Scan oldest to youngest so the youngest matching entry overrides any older one.
    always_comb begin
        for (int op = 0; op < 2; op++) begin
            op_found[op]  = 1'b0;
            op_hazard[op] = 1'b0;
            op_idx[op]    = SelWidth'(DEPTH);
            op_data[op]   = '0;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (op_used[op] && (op_addr[op] != '0) && live[i] &&
                    (dest_q[i] == op_addr[op])) begin
                    op_found[op]  = 1'b1;
                    op_hazard[op] = load_q[i] && (i < int'(LOAD_USE_STAGES));
                    op_idx[op]    = i[SelWidth-1:0];
                    op_data[op]   = stage_result[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            op_hit[op] = op_found[op] & ~op_hazard[op];
        end
    end

    assign stall       = id_valid & (|op_hazard) & ~flush;
    assign fwd_rs_hit  = op_hit[0];
    assign fwd_rt_hit  = op_hit[1];
    assign fwd_rs_sel  = op_hit[0] ? op_idx[0] : SelWidth'(DEPTH);
    assign fwd_rt_sel  = op_hit[1] ? op_idx[1] : SelWidth'(DEPTH);
    assign fwd_rs_data = op_hit[0] ? op_data[0] : '0;
    assign fwd_rt_data = op_hit[1] ? op_data[1] : '0;

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_cnt = valid_cnt + SelWidth'(valid_q[i]);
        end
    end

    assign in_flight   = valid_cnt;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q       <= '0;
            writes_q      <= '0;
            load_q        <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
                // flush kills the instruction in entry 0 before it moves on
                valid_q[i]  <= (i == 1 && flush) ? 1'b0 : valid_q[i-1];
                writes_q[i] <= writes_q[i-1];
                load_q[i]   <= load_q[i-1];
                dest_q[i]   <= dest_q[i-1];
            end
            valid_q[0]  <= id_valid & ~flush & ~stall;
            writes_q[0] <= id_writes_reg;
            load_q[0]   <= id_is_load;
            dest_q[0]   <= id_dest_addr;
            if (stall && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
            if (flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two configurations (3-deep/LUS 1/16-bit counters and 5-deep/LUS 2/4-bit
// counters) share the ID stimulus. A reference model predicts every cycle's outputs into a queue;
// a monitor pops and compares mid-cycle.
module tb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_dest_addr = '0;
    logic        id_writes_reg = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [31:0] sr [5];

    logic        a_stall, a_rs_hit, a_rt_hit;
    logic [1:0]  a_rs_sel, a_rt_sel, a_in_flight;
    logic [31:0] a_rs_data, a_rt_data;
    logic [15:0] a_stall_count, a_flush_count;

    logic        b_stall, b_rs_hit, b_rt_hit;
    logic [2:0]  b_rs_sel, b_rt_sel, b_in_flight;
    logic [31:0] b_rs_data, b_rt_data;
    logic [3:0]  b_stall_count, b_flush_count;

    always #5 clock = ~clock;

    hazard_scoreboard u_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_writes_reg(id_writes_reg), .id_dest_addr(id_dest_addr), .id_is_load(id_is_load),
        .flush(flush), .stage_result({sr[2], sr[1], sr[0]}), .stall(a_stall),
        .fwd_rs_hit(a_rs_hit), .fwd_rt_hit(a_rt_hit), .fwd_rs_sel(a_rs_sel),
        .fwd_rt_sel(a_rt_sel), .fwd_rs_data(a_rs_data), .fwd_rt_data(a_rt_data),
        .in_flight(a_in_flight), .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    hazard_scoreboard #(.DEPTH(5), .LOAD_USE_STAGES(2), .COUNT_WIDTH(4)) u_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_writes_reg(id_writes_reg), .id_dest_addr(id_dest_addr), .id_is_load(id_is_load),
        .flush(flush), .stage_result({sr[4], sr[3], sr[2], sr[1], sr[0]}), .stall(b_stall),
        .fwd_rs_hit(b_rs_hit), .fwd_rt_hit(b_rt_hit), .fwd_rs_sel(b_rs_sel),
        .fwd_rt_sel(b_rt_sel), .fwd_rs_data(b_rs_data), .fwd_rt_data(b_rt_data),
        .in_flight(b_in_flight), .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit valid;
        bit writes;
        bit is_load;
        int dest;
    } ent_t;

    typedef struct {
        int m;
        int stall, rs_hit, rt_hit, rs_sel, rt_sel, in_flight, stall_count, flush_count;
        longint rs_data, rt_data;
    } exp_t;

    ent_t hist [2][8];
    int   depth_m [2] = '{3, 5};
    int   lus_m   [2] = '{1, 2};
    int   cmax_m  [2] = '{65535, 15};
    int   scnt [2];
    int   fcnt [2];
    exp_t exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) hist[m][i] = '{0, 0, 0, 0};
            scnt[m] = 0;
            fcnt[m] = 0;
        end
    endfunction

    // Youngest live entry with a matching dest decides: load too close -> hazard, else forward.
    function automatic void resolve(input int m, input bit used, input int addr,
                                    output int hit, output int hz, output int sel,
                                    output longint data);
        bit done = 0;
        hit = 0; hz = 0; sel = depth_m[m]; data = 0;
        if (used && addr != 0) begin
            for (int i = 0; i < depth_m[m]; i++) begin
                if (!done && hist[m][i].valid && hist[m][i].writes && hist[m][i].dest == addr) begin
                    done = 1;
                    if (hist[m][i].is_load && i < lus_m[m]) hz = 1;
                    else begin
                        hit = 1; sel = i; data = longint'(sr[i]);
                    end
                end
            end
        end
    endfunction

    function automatic int predict(input int m);
        exp_t e;
        int hz_rs, hz_rt, n;
        e.m = m;
        resolve(m, id_uses_rs, int'(id_rs_addr), e.rs_hit, hz_rs, e.rs_sel, e.rs_data);
        resolve(m, id_uses_rt, int'(id_rt_addr), e.rt_hit, hz_rt, e.rt_sel, e.rt_data);
        e.stall = (id_valid && (hz_rs || hz_rt) && !flush) ? 1 : 0;
        n = 0;
        for (int i = 0; i < depth_m[m]; i++) if (hist[m][i].valid) n++;
        e.in_flight   = n;
        e.stall_count = scnt[m];
        e.flush_count = fcnt[m];
        exp_q.push_back(e);
        return e.stall;
    endfunction

    function automatic void advance(input int m, input int st);
        if (st != 0 && scnt[m] < cmax_m[m]) scnt[m]++;
        if (flush && fcnt[m] < cmax_m[m]) fcnt[m]++;
        if (flush) hist[m][0].valid = 0;
        for (int i = depth_m[m] - 1; i >= 1; i--) hist[m][i] = hist[m][i-1];
        hist[m][0] = '{id_valid && !flush && st == 0, id_writes_reg, id_is_load, int'(id_dest_addr)};
    endfunction

    // One cycle: inputs already set at negedge; predict, then advance model at the edge.
    task automatic step();
        int st [2];
        for (int i = 0; i < 5; i++) sr[i] = $urandom;
        if (!reset) model_clear();
        for (int m = 0; m < 2; m++) st[m] = predict(m);
        @(posedge clock);
        if (reset) for (int m = 0; m < 2; m++) advance(m, st[m]);
        @(negedge clock);
    endtask

    task automatic issue(input bit v, input bit urs, input int rs, input bit urt, input int rt,
                         input bit wr, input int dst, input bit ld, input bit fl);
        id_valid = v; id_uses_rs = urs; id_rs_addr = 5'(rs); id_uses_rt = urt;
        id_rt_addr = 5'(rt); id_writes_reg = wr; id_dest_addr = 5'(dst); id_is_load = ld;
        flush = fl;
        step();
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input int m, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, m, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.m == 0) begin
                    check("stall", 0, a_stall, e.stall);
                    check("rs_hit", 0, a_rs_hit, e.rs_hit);
                    check("rt_hit", 0, a_rt_hit, e.rt_hit);
                    check("rs_sel", 0, a_rs_sel, e.rs_sel);
                    check("rt_sel", 0, a_rt_sel, e.rt_sel);
                    check("rs_data", 0, a_rs_data, e.rs_data);
                    check("rt_data", 0, a_rt_data, e.rt_data);
                    check("in_flight", 0, a_in_flight, e.in_flight);
                    check("stall_count", 0, a_stall_count, e.stall_count);
                    check("flush_count", 0, a_flush_count, e.flush_count);
                end else begin
                    check("stall", 1, b_stall, e.stall);
                    check("rs_hit", 1, b_rs_hit, e.rs_hit);
                    check("rt_hit", 1, b_rt_hit, e.rt_hit);
                    check("rs_sel", 1, b_rs_sel, e.rs_sel);
                    check("rt_sel", 1, b_rt_sel, e.rt_sel);
                    check("rs_data", 1, b_rs_data, e.rs_data);
                    check("rt_data", 1, b_rt_data, e.rt_data);
                    check("in_flight", 1, b_in_flight, e.in_flight);
                    check("stall_count", 1, b_stall_count, e.stall_count);
                    check("flush_count", 1, b_flush_count, e.flush_count);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        issue(1, 1, 3, 1, 3, 1, 3, 0, 0);   // reset state, ID inputs ignored by state
        issue(1, 1, 3, 1, 3, 1, 3, 1, 0);
        reset = 1'b1;

        // add r3 ; sub r4,r3
        issue(1, 1, 1, 1, 2, 1, 3, 0, 0);
        issue(1, 1, 3, 1, 2, 1, 4, 0, 0);
        // lw r5 ; add r6,r5 held until it gets through
        issue(1, 1, 1, 0, 0, 1, 5, 1, 0);
        repeat (3) issue(1, 1, 5, 1, 1, 1, 6, 0, 0);
        // r7 written at two ages, read on both operands
        issue(1, 0, 0, 0, 0, 1, 7, 0, 0);
        issue(1, 0, 0, 0, 0, 1, 9, 0, 0);
        issue(1, 0, 0, 0, 0, 1, 7, 0, 0);
        issue(1, 1, 7, 1, 7, 1, 10, 0, 0);
        // r0 destination then read of r0
        issue(1, 0, 0, 0, 0, 1, 0, 0, 0);
        issue(1, 1, 0, 1, 0, 1, 11, 0, 0);
        // load-use hazard coinciding with flush
        issue(1, 0, 0, 0, 0, 1, 12, 1, 0);
        issue(1, 1, 12, 1, 12, 1, 13, 0, 1);
        issue(1, 1, 12, 1, 12, 0, 0, 0, 0);
        // lw r8, two independents, reader
        issue(1, 0, 0, 0, 0, 1, 8, 1, 0);
        issue(1, 0, 0, 0, 0, 1, 14, 0, 0);
        issue(1, 0, 0, 0, 0, 1, 15, 0, 0);
        issue(1, 1, 8, 0, 0, 1, 16, 0, 0);
        // drive the small counter past its ceiling
        repeat (10) begin
            issue(1, 0, 0, 0, 0, 1, 5, 1, 0);
            repeat (2) issue(1, 1, 5, 1, 5, 1, 6, 0, 0);
        end
        repeat (20) issue(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // mid-run reset
        issue(1, 0, 0, 0, 0, 1, 17, 0, 0);
        reset = 1'b0;
        issue(1, 1, 17, 1, 17, 1, 18, 1, 0);
        reset = 1'b1;
        issue(1, 1, 17, 1, 17, 1, 18, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            issue(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
        end
        reset = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #5;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
